// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: button sync/edge detect, PC, imem stepping, halt detect.
// Optional per-button debounce counters are enabled by defining IFU_DEBOUNCE_EN.
module instr_fetch_unit #(
  parameter int          IW              = 12,
  parameter int          PC_W            = 4,
  parameter logic [2:0]  HALT_OP         = 3'b111,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pushBtnLeft,
  input  logic            pushBtnRight,
  input  logic [IW-1:0]   switches,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IW-1:0]   imem_data,
  output logic [IW-1:0]   ir_out,
  output logic            ir_valid,
  input  logic            ir_ready,
  output logic            ir_from_sw,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_t;

  // bit 0 = left (step), bit 1 = right (immediate)
  logic [1:0] sync1_q, sync2_q, sync3_q;
  logic [1:0] sync1_d, sync2_d, sync3_d;
  logic [1:0] lvl;
  logic [1:0] pulse;

`ifdef IFU_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    db_q, db_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  always_comb begin
    db_d = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      db_q <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign lvl = db_q;
`else
  assign lvl = sync2_q;
`endif

  always_comb begin
    sync1_d = {pushBtnRight, pushBtnLeft};
    sync2_d = sync1_q;
    sync3_d = lvl;
    pulse = lvl & ~sync3_q;
  end

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic            valid_q, valid_d;
  logic            from_sw_q, from_sw_d;
  logic            halted_q, halted_d;
  logic            en_q, en_d;
  logic [PC_W-1:0] addr_q, addr_d;

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    valid_d = valid_q;
    from_sw_d = from_sw_q;
    halted_d = halted_q;
    en_d = 1'b0;
    addr_d = addr_q;
    unique case (state_q)
      S_IDLE: begin
        // right wins a same-cycle tie; the left pulse is simply dropped
        if (pulse[1]) begin
          ir_d = switches;
          from_sw_d = 1'b1;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end else if (pulse[0] && !halted_q) begin
          en_d = 1'b1;
          addr_d = pc_q;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (imem_data[IW-1 -: 3] == HALT_OP) begin
          halted_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          ir_d = imem_data;
          from_sw_d = 1'b0;
          pc_d = pc_q + PC_W'(1);
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ir_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      state_q <= S_IDLE;
      pc_q <= '0;
      ir_q <= '0;
      valid_q <= 1'b0;
      from_sw_q <= 1'b0;
      halted_q <= 1'b0;
      en_q <= 1'b0;
      addr_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      valid_q <= valid_d;
      from_sw_q <= from_sw_d;
      halted_q <= halted_d;
      en_q <= en_d;
      addr_q <= addr_d;
    end
  end

  assign imem_en = en_q;
  assign imem_addr = addr_q;
  assign ir_out = ir_q;
  assign ir_valid = valid_q;
  assign ir_from_sw = from_sw_q;
  assign pc = pc_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed steps plus random steps against a PC/halt model.
// Honours IFU_DEBOUNCE_EN for latency and the glitch-rejection step.
module tb_instr_fetch_unit;

`ifdef IFU_DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif
  localparam int NCYC = 2 * DB + 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pushBtnLeft = 1'b0;
  logic        pushBtnRight = 1'b0;
  logic [11:0] switches = '0;
  logic        imem_en;
  logic [3:0]  imem_addr;
  logic [11:0] imem_data = '0;
  logic [11:0] ir_out;
  logic        ir_valid;
  logic        ir_ready = 1'b1;
  logic        ir_from_sw;
  logic [3:0]  pc;
  logic        halted;

  instr_fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .pushBtnLeft(pushBtnLeft),
    .pushBtnRight(pushBtnRight),
    .switches(switches),
    .imem_en(imem_en),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .ir_out(ir_out),
    .ir_valid(ir_valid),
    .ir_ready(ir_ready),
    .ir_from_sw(ir_from_sw),
    .pc(pc),
    .halted(halted)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [16];

  always @(posedge clk) begin
    if (imem_en) imem_data <= mem[imem_addr];
  end

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total = 0;

  // model state
  int          m_pc = 0;
  bit          m_halt = 0;
  logic [11:0] m_ir = '0;
  bit          m_sw = 0;

  // capture from last press
  int          vlat;
  logic        en_seen;
  logic [3:0]  en_addr;
  logic [11:0] cap_ir;
  logic        cap_sw;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_pc = 0;
    m_halt = 0;
    m_ir = '0;
    m_sw = 0;
  endtask

  task automatic do_press(input logic l, input logic r);
    @(negedge clk);
    pushBtnLeft = l;
    pushBtnRight = r;
    vlat = -1;
    en_seen = 1'b0;
    en_addr = '0;
    cap_ir = '0;
    cap_sw = 1'b0;
    for (int i = 1; i <= NCYC; i++) begin
      @(negedge clk);
      if (i == DB + 3) begin
        pushBtnLeft = 1'b0;
        pushBtnRight = 1'b0;
      end
      if (imem_en && !en_seen) begin
        en_seen = 1'b1;
        en_addr = imem_addr;
      end
      if (ir_valid && vlat < 0) begin
        vlat = i;
        cap_ir = ir_out;
        cap_sw = ir_from_sw;
      end
    end
  endtask

  task automatic step(input string tag, input logic l, input logic r,
                      input logic [11:0] sw);
    int          e_lat;
    bit          e_en;
    logic [3:0]  e_addr;
    logic [11:0] w;
    switches = sw;
    do_press(l, r);
    e_lat = -1;
    e_en = 0;
    e_addr = '0;
    if (r) begin
      m_ir = sw;
      m_sw = 1;
      e_lat = 3 + DB;
    end else if (l && !m_halt) begin
      e_en = 1;
      e_addr = 4'(m_pc);
      w = mem[m_pc];
      if (w[11:9] == 3'b111) begin
        m_halt = 1;
      end else begin
        m_ir = w;
        m_sw = 0;
        m_pc = (m_pc + 1) % 16;
        e_lat = 5 + DB;
      end
    end
    chk({tag, ".lat"}, vlat, e_lat);
    chk({tag, ".en"}, {31'd0, en_seen}, {31'd0, e_en});
    if (e_en) chk({tag, ".addr"}, {28'd0, en_addr}, {28'd0, e_addr});
    if (e_lat >= 0) begin
      chk({tag, ".cap_ir"}, {20'd0, cap_ir}, {20'd0, m_ir});
      chk({tag, ".cap_sw"}, {31'd0, cap_sw}, {31'd0, m_sw});
    end
    chk({tag, ".ir"}, {20'd0, ir_out}, {20'd0, m_ir});
    chk({tag, ".pc"}, {28'd0, pc}, m_pc);
    chk({tag, ".halt"}, {31'd0, halted}, {31'd0, m_halt});
    chk({tag, ".valid"}, {31'd0, ir_valid}, 32'd0);
  endtask

  function automatic logic [11:0] rand_word();
    logic [11:0] w;
    w = 12'($urandom);
    if (w[11:9] == 3'b111) w[11] = 1'b0;
    return w;
  endfunction

  initial begin
    logic [11:0] held;
    for (int i = 0; i < 16; i++) mem[i] = rand_word();
    mem[0] = 12'h0A3;
    mem[1] = 12'hA45;
    mem[15] = 12'h200;

    do_reset();
    chk("rst.ir", {20'd0, ir_out}, 32'd0);
    chk("rst.valid", {31'd0, ir_valid}, 32'd0);
    chk("rst.sw", {31'd0, ir_from_sw}, 32'd0);
    chk("rst.pc", {28'd0, pc}, 32'd0);
    chk("rst.halt", {31'd0, halted}, 32'd0);
    chk("rst.en", {31'd0, imem_en}, 32'd0);
    chk("rst.addr", {28'd0, imem_addr}, 32'd0);

    step("w0", 1'b1, 1'b0, 12'h000);
    step("w1", 1'b1, 1'b0, 12'h000);
    step("sw", 1'b0, 1'b1, 12'hC1D);

    // stall in HOLD, buttons pressed meanwhile must be dropped
    ir_ready = 1'b0;
    switches = 12'h5A5;
    do_press(1'b1, 1'b0);
    chk("hold.lat", vlat, 5 + DB);
    chk("hold.cap", {20'd0, cap_ir}, {20'd0, mem[2]});
    m_ir = mem[2];
    m_sw = 0;
    m_pc = 3;
    held = ir_out;
    do_press(1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("hold.en", {31'd0, en_seen}, 32'd0);
    chk("hold.valid", {31'd0, ir_valid}, 32'd1);
    chk("hold.ir", {20'd0, ir_out}, {20'd0, held});
    chk("hold.pc", {28'd0, pc}, m_pc);
    ir_ready = 1'b1;
    @(negedge clk);
    chk("hold.drop", {31'd0, ir_valid}, 32'd0);
    repeat (8) @(negedge clk);
    chk("hold.noq", {31'd0, ir_valid | imem_en}, 32'd0);

    // step through to pc 15 and wrap
    while (m_pc != 15) step("run", 1'b1, 1'b0, 12'h000);
    step("w15", 1'b1, 1'b0, 12'h000);
    chk("wrap.pc", {28'd0, pc}, 32'd0);
    chk("wrap.ir", {20'd0, ir_out}, 32'h200);

    step("both", 1'b1, 1'b1, 12'h3C7);

    for (int k = 0; k < 8; k++) begin
      logic [1:0] b;
      b = 2'($urandom_range(1, 3));
      step("rnd", b[0], b[1], 12'($urandom));
    end

`ifdef IFU_DEBOUNCE_EN
    @(negedge clk);
    pushBtnRight = 1'b1;
    repeat (5) @(negedge clk);
    pushBtnRight = 1'b0;
    vlat = -1;
    for (int i = 0; i < 3 * DB; i++) begin
      @(negedge clk);
      if (ir_valid && vlat < 0) vlat = i;
    end
    chk("glitch", vlat, -1);
`endif

    // halt at pc 2
    mem[2] = 12'hE00;
    do_reset();
    step("h0", 1'b1, 1'b0, 12'h000);
    step("h1", 1'b1, 1'b0, 12'h000);
    step("halt", 1'b1, 1'b0, 12'h000);
    chk("halt.pc", {28'd0, pc}, 32'd2);
    chk("halt.flag", {31'd0, halted}, 32'd1);
    step("hl", 1'b1, 1'b0, 12'h000);
    step("hr", 1'b0, 1'b1, 12'h0F1);
    do_reset();
    chk("rst2.halt", {31'd0, halted}, 32'd0);
    chk("rst2.pc", {28'd0, pc}, 32'd0);
    chk("rst2.ir", {20'd0, ir_out}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
